btn_pulse_gen: RTL and testbench
================================

Name: btn_pulse_gen

Overview:
- Conditions the three raw front-panel push-buttons into the single-cycle command strobes `Enter`, `U` and `LU` consumed by the calculator control FSM.
- Per-channel path: two-flop synchroniser, then debounce FSM, then press-edge detection.
- A priority arbiter ensures at most one strobe is asserted per clock, so the downstream FSM never sees simultaneous commands.
- Sits between the board pins and the control block.

Parameters:
- DEB_CYCLES, 1000000, number of consecutive stable synchronised samples required to accept a press or a release (20 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 25000000, cycles a press must be held before the first auto-repeat (used only with AUTOREPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeats (used only with AUTOREPEAT_EN).

Ports:
- clk  in  1  system clock
- clr_n  in  1  reset; asynchronous, active-low
- btn_enter  in  1  raw Enter button, active-high, asynchronous
- btn_u  in  1  raw U button, active-high, asynchronous
- btn_lu  in  1  raw LU button, active-high, asynchronous
- Enter  out  1  registered one-cycle strobe per accepted Enter press
- U  out  1  registered one-cycle strobe per accepted U press (or repeat)
- LU  out  1  registered one-cycle strobe per accepted LU press
- held  out  3  debounced button levels {lu,u,enter}, registered

Behaviour:
- Reset (clr_n=0, async):
  - All synchroniser flops, counters and pending bits clear to 0.
  - All channel FSMs go to IDLE.
  - Enter=U=LU=0 and held=0.
  - Takes effect immediately, including mid-debounce or while a pulse is pending; pending presses are discarded.
- Synchroniser: two flops per channel. `s` denotes the second flop.
- Channel FSM states and transitions:
  - IDLE:
    - s=1: go to PRESS_WAIT, cnt=1.
  - PRESS_WAIT:
    - s=0 (bounce): go to IDLE, cnt=0.
    - s=1 and cnt==DEB_CYCLES-1: go to PRESSED, set pend, set held bit, cnt=0.
    - Otherwise: cnt++.
  - PRESSED:
    - s=0: go to RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT:
    - s=1: go back to PRESSED, cnt=0; no new pulse.
    - s=0 and cnt==DEB_CYCLES-1: go to IDLE, clear held bit.
    - Otherwise: cnt++.
- Counter width: $clog2(max(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1).
- Release never generates a strobe.
- Latency: raw input high and stable before edge 0 gives a strobe high during cycle DEB_CYCLES+3, if the arbiter is uncontended.
- Arbiter:
  - Each cycle, the highest-priority pending bit is registered onto its strobe and cleared.
  - Priority: Enter > LU > U.
  - Losers stay pending and are emitted on subsequent cycles.
  - Strobes are one-hot or zero every cycle.
- Pend saturates: a new acceptance on a channel whose pend is already set yields a single strobe.
- Strobes are registered: a strobe is high for exactly one cycle, then low unless a further pend is granted.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- When defined, the U channel only auto-repeats:
  - In PRESSED, a repeat counter counts cycles.
  - At REPEAT_DELAY after entering PRESSED, set pend.
  - Thereafter set pend every REPEAT_PERIOD cycles while still in PRESSED.
  - Leaving PRESSED (entering RELEASE_WAIT) clears the repeat counter.
  - A bounce back to PRESSED restarts REPEAT_DELAY.
- When undefined: no repeat logic, and REPEAT_* parameters are ignored.

Decomposition:
- Package btn_pkg:
  - Channel state enum {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
  - Channel index constants CH_ENTER=0, CH_U=1, CH_LU=2.
  - Priority-order constant.
- Sub-module btn_debounce (one per channel, parameterised by DEB_CYCLES and an auto-repeat enable):
  - Contains the synchroniser, FSM and counter.
  - Outputs held and a one-cycle accept signal.
- Top-level holds the pend bits, the arbiter and the output registers.

Test Plan (all scenarios use DEB_CYCLES=4):
- Reset: drive clr_n=0 mid-PRESS_WAIT, then release reset -> all outputs 0 immediately; no strobe for the interrupted press.
- Clean press: btn_enter high 20 cycles from edge 0 -> Enter=1 only in cycle 7, held[0]=1 from cycle 7; no strobe on release; held[0]=0 four cycles after the synchronised fall.
- Bounce: btn_u pattern (3 high, 1 low) x5, then high 10 cycles -> no U strobe during the bounce; exactly one U strobe, 7 cycles after the final rise.
- Simultaneous: btn_enter and btn_lu rise on the same edge -> Enter in cycle 7, LU in cycle 8, never both asserted together.
- Triple contention: all three buttons rise together -> Enter in cycle 7, LU in cycle 8, U in cycle 9.
- Auto-repeat: with BTN_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5, hold btn_u 30 cycles -> U strobes in cycles 7, 17, 22, 27 and 32; none after release.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning block.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } ch_state_e;

  localparam int NUM_CH   = 3;
  localparam int CH_ENTER = 0;
  localparam int CH_U     = 1;
  localparam int CH_LU    = 2;

  // Arbiter scan order, highest priority first.
  localparam int PRIO_ORDER [NUM_CH] = '{CH_ENTER, CH_LU, CH_U};

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, debounce FSM and accept strobe,
// with an optional hold-to-repeat generator enabled per instance.
module btn_debounce #(
  parameter int DEB_CYCLES    = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter bit AUTOREPEAT_EN = 1'b0
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic held,
  output logic accept
);
  import btn_pkg::*;

  localparam int CNT_W = $clog2(max3(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [1:0]       sync;
  logic             s;
  ch_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             press_fire;
  logic             rep_fire;

  assign s          = sync[1];
  assign press_fire = (state == PRESS_WAIT) && s && (cnt == DEB_LAST);
  assign accept     = press_fire || rep_fire;

  // NOTE: sequential state is updated with <= only, so every flop samples
  // pre-edge values and the synchroniser really is two stages deep.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
      held  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= ONE;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= PRESSED;
            held  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= ONE;
          end
        end
        RELEASE_WAIT: begin
          // A bounce while releasing returns to PRESSED without a new accept.
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= IDLE;
            held  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  if (AUTOREPEAT_EN) begin : g_rep
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rep_cnt;
    logic             rep_first;
    logic [CNT_W-1:0] rep_last;

    assign rep_last = rep_first ? RD_LAST : RP_LAST;
    assign rep_fire = (state == PRESSED) && s && (rep_cnt == rep_last);

    // Counts only while held in PRESSED; any exit rearms the initial delay.
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if ((state == PRESSED) && s) begin
        if (rep_cnt == rep_last) begin
          rep_cnt   <= '0;
          rep_first <= 1'b0;
        end else begin
          rep_cnt <= rep_cnt + ONE;
        end
      end else begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end
    end
  end else begin : g_no_rep
    assign rep_fire = 1'b0;
  end

endmodule

// File: rtl/btn_pulse_gen.sv
// Front-panel button conditioner: three debounced channels feeding a priority
// arbiter of one-cycle command strobes. Define BTN_AUTOREPEAT_EN for U auto-repeat.
module btn_pulse_gen #(
  parameter int DEB_CYCLES    = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       btn_enter,
  input  logic       btn_u,
  input  logic       btn_lu,
  output logic       Enter,
  output logic       U,
  output logic       LU,
  output logic [2:0] held
);
  import btn_pkg::*;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit U_REPEAT = 1'b1;
`else
  localparam bit U_REPEAT = 1'b0;
`endif

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] deb_held;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] strobe;

  assign raw[CH_ENTER] = btn_enter;
  assign raw[CH_U]     = btn_u;
  assign raw[CH_LU]    = btn_lu;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    btn_debounce #(
      .DEB_CYCLES    (DEB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .AUTOREPEAT_EN ((ch == CH_U) && U_REPEAT)
    ) u_deb (
      .clk    (clk),
      .clr_n  (clr_n),
      .btn    (raw[ch]),
      .held   (deb_held[ch]),
      .accept (accept[ch])
    );
  end

  // NOTE: grant is cleared before the scan so every path assigns it and no
  // latch is inferred.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend[PRIO_ORDER[i]] && (grant == '0)) grant[PRIO_ORDER[i]] = 1'b1;
    end
  end

  // Pending bits saturate; a grant and a fresh accept on the same channel
  // leave it pending for one more strobe.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pend   <= '0;
      strobe <= '0;
      held   <= '0;
    end else begin
      pend   <= (pend & ~grant) | accept;
      strobe <= grant;
      held   <= deb_held;
    end
  end

  assign Enter = strobe[CH_ENTER];
  assign U     = strobe[CH_U];
  assign LU    = strobe[CH_LU];

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Self-checking bench for btn_pulse_gen: directed scenarios plus random button
// traffic against a run-length debounce model with a priority pending set.
module tb_btn_pulse_gen;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       btn_enter = 1'b0;
  logic       btn_u = 1'b0;
  logic       btn_lu = 1'b0;
  logic       Enter, U, LU;
  logic [2:0] held;

  btn_pulse_gen #(
    .DEB_CYCLES    (DEB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .btn_enter (btn_enter),
    .btn_u     (btn_u),
    .btn_lu    (btn_lu),
    .Enter     (Enter),
    .U         (U),
    .LU        (LU),
    .held      (held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: bit 0 enter, bit 1 u, bit 2 lu.
  bit [2:0] m_s1, m_s, m_level, m_pend;
  int       m_run [3];
`ifdef BTN_AUTOREPEAT_EN
  int       m_hold;
`endif

  int cyc;
  int log_e[$], log_u[$], log_l[$];
  int h_rise, h_fall;
  bit prev_h0;

  task automatic model_reset();
    m_s1 = '0; m_s = '0; m_level = '0; m_pend = '0;
    for (int c = 0; c < 3; c++) m_run[c] = 0;
`ifdef BTN_AUTOREPEAT_EN
    m_hold = -1;
`endif
    prev_h0 = 1'b0;
  endtask

  task automatic start_scn();
    log_e.delete(); log_u.delete(); log_l.delete();
    cyc = 0; h_rise = -1; h_fall = -1;
  endtask

  task automatic tick();
    bit [2:0] raw, samp, acc, grant, exp_held;
    raw = {btn_lu, btn_u, btn_enter};
    @(posedge clk);
    #1;
    samp = m_s; m_s = m_s1; m_s1 = raw;
    grant = '0;
    if (m_pend[0])      grant = 3'b001;
    else if (m_pend[2]) grant = 3'b100;
    else if (m_pend[1]) grant = 3'b010;
    exp_held = m_level;
    acc = '0;
`ifdef BTN_AUTOREPEAT_EN
    if (m_level[1]) begin
      if (!samp[1]) m_hold = -1;
      else begin
        if (m_hold < 0) m_hold = 0;
        else m_hold++;
        if (m_hold >= RD && ((m_hold - RD) % RP) == 0) acc[1] = 1'b1;
      end
    end
`endif
    for (int c = 0; c < 3; c++) begin
      if (samp[c] != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == DEB) begin
          m_level[c] = samp[c];
          m_run[c] = 0;
          if (samp[c]) acc[c] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          if (c == 1 && samp[c]) m_hold = 0;
`endif
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_pend = (m_pend & ~grant) | acc;
    check("strobes", {29'd0, LU, U, Enter}, {29'd0, grant});
    check("held", {29'd0, held}, {29'd0, exp_held});
    check("onehot", {31'd0, ($countones({LU, U, Enter}) <= 1)}, 32'd1);
    if (Enter) log_e.push_back(cyc + 1);
    if (U)     log_u.push_back(cyc + 1);
    if (LU)    log_l.push_back(cyc + 1);
    if (held[0] && !prev_h0 && h_rise < 0) h_rise = cyc + 1;
    if (!held[0] && prev_h0) h_fall = cyc + 1;
    prev_h0 = held[0];
    cyc++;
  endtask

  task automatic idle(input int n);
    btn_enter = 1'b0; btn_u = 1'b0; btn_lu = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset(input string tag);
    clr_n = 1'b0;
    #1;
    check({tag, "_strobes"}, {29'd0, LU, U, Enter}, 32'd0);
    check({tag, "_held"}, {29'd0, held}, 32'd0);
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic check_log(input string tag, input int got[$], input int n,
                           input int e0, input int e1, input int e2, input int e3, input int e4);
    int e [5];
    e = '{e0, e1, e2, e3, e4};
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) check(tag, got[i], e[i]);
  endtask

  bit lvl [3];
  int rem [3];

  initial begin
    model_reset();
    #1 clr_n = 1'b0;
    #2;
    check("por_strobes", {29'd0, LU, U, Enter}, 32'd0);
    check("por_held", {29'd0, held}, 32'd0);
    @(negedge clk); @(negedge clk);
    clr_n = 1'b1;
    idle(4);

    // Reset in the middle of PRESS_WAIT discards the press.
    start_scn();
    btn_enter = 1'b1;
    repeat (3) tick();
    btn_enter = 1'b0;
    do_reset("rst_pw");
    start_scn();
    idle(12);
    check_log("rst_pw_enter", log_e, 0, 0, 0, 0, 0, 0);
    check("rst_pw_held_rise", h_rise, -1);

    // Reset while a strobe is being driven clears outputs at once.
    start_scn();
    btn_enter = 1'b1;
    repeat (7) tick();
    btn_enter = 1'b0;
    do_reset("rst_pulse");
    idle(12);
    check_log("rst_pulse_enter", log_e, 1, 7, 0, 0, 0, 0);

    // Clean press and release.
    start_scn();
    btn_enter = 1'b1;
    repeat (20) tick();
    idle(12);
    check_log("clean_enter", log_e, 1, 7, 0, 0, 0, 0);
    check("clean_held_rise", h_rise, 7);
    check("clean_held_fall", h_fall, 27);

    // Bounce on U, then a steady press.
    start_scn();
    repeat (5) begin
      btn_u = 1'b1; repeat (3) tick();
      btn_u = 1'b0; tick();
    end
    btn_u = 1'b1;
    repeat (10) tick();
    idle(12);
    check_log("bounce_u", log_u, 1, 27, 0, 0, 0, 0);

    // Enter and LU together.
    start_scn();
    btn_enter = 1'b1; btn_lu = 1'b1;
    repeat (10) tick();
    idle(12);
    check_log("simul_enter", log_e, 1, 7, 0, 0, 0, 0);
    check_log("simul_lu", log_l, 1, 8, 0, 0, 0, 0);

    // All three together.
    start_scn();
    btn_enter = 1'b1; btn_u = 1'b1; btn_lu = 1'b1;
    repeat (10) tick();
    idle(12);
    check_log("tri_enter", log_e, 1, 7, 0, 0, 0, 0);
    check_log("tri_lu", log_l, 1, 8, 0, 0, 0, 0);
    check_log("tri_u", log_u, 1, 9, 0, 0, 0, 0);

    // Long U hold.
    start_scn();
    btn_u = 1'b1;
    repeat (30) tick();
    idle(15);
`ifdef BTN_AUTOREPEAT_EN
    check_log("hold_u", log_u, 5, 7, 17, 22, 27, 32);
`else
    check_log("hold_u", log_u, 1, 7, 0, 0, 0, 0);
`endif

    // Random traffic on all channels against the model.
    start_scn();
    for (int c = 0; c < 3; c++) begin lvl[c] = 1'b0; rem[c] = 0; end
    for (int t = 0; t < 1500; t++) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = ($urandom_range(0, 1) == 1);
          rem[c] = $urandom_range(1, 24);
        end
        rem[c]--;
      end
      btn_enter = lvl[0]; btn_u = lvl[1]; btn_lu = lvl[2];
      tick();
      if (t == 700) begin
        btn_enter = 1'b0; btn_u = 1'b0; btn_lu = 1'b0;
        for (int c = 0; c < 3; c++) begin lvl[c] = 1'b0; rem[c] = 0; end
        do_reset("rand_rst");
      end
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
